// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core constants and hazard unit state type
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    localparam int MD_LATENCY_DEFAULT = 4;
    localparam int MD_CNT_W = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        MD_RUN = 1'b1
    } md_state_e;

    // Initial down-counter value for a mult/div of the given EX occupancy.
    function automatic logic [MD_CNT_W-1:0] md_cnt_init(input int latency);
        return MD_CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with increment enable
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Increment when enabled, holding at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use / mult-div stall and branch flush control
module hazard_stall_unit
    import mips_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] id_ex_write_reg_addr,
    input  logic [REG_ADDR_W-1:0] if_id_instr_rs,
    input  logic [REG_ADDR_W-1:0] if_id_instr_rt,
    input  logic                  if_id_uses_rt,
    input  logic                  if_id_reads_hilo,
    input  logic                  if_id_is_md,
    input  logic                  md_start,
    input  logic                  branch_taken,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_ex_bubble,
    output logic                  if_id_flush,
    output logic                  md_busy,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam logic [MD_CNT_W-1:0] MD_CNT_START = md_cnt_init(MD_LATENCY);

    md_state_e           state_q;
    md_state_e           state_d;
    logic [MD_CNT_W-1:0] md_cnt_q;
    logic [MD_CNT_W-1:0] md_cnt_d;

    logic load_use;
    logic md_hazard;
    logic stall;
    logic stall_count_inc;

    // Track mult/div EX occupancy; a start while already running is ignored
    // because the issuing instruction would have been held in ID.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            IDLE: begin
                if (md_start) begin
                    state_d  = MD_RUN;
                    md_cnt_d = MD_CNT_START;
                end
            end
            MD_RUN: begin
                if (md_cnt_q == MD_CNT_W'(1)) begin
                    state_d  = IDLE;
                    md_cnt_d = '0;
                end else begin
                    md_cnt_d = md_cnt_q - MD_CNT_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                md_cnt_d = '0;
            end
        endcase
    end

    // Mult/div state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    assign md_busy = (state_q == MD_RUN);

    // Hazard detection and pipeline control; a taken branch squashes the
    // wrong-path instruction in ID, so it wins over any stall.
    always_comb begin
        load_use = id_ex_mem_read
                && (id_ex_write_reg_addr != REG_ZERO)
                && ((id_ex_write_reg_addr == if_id_instr_rs)
                    || (if_id_uses_rt && (id_ex_write_reg_addr == if_id_instr_rt)));
        md_hazard = md_busy && (if_id_reads_hilo || if_id_is_md);
        stall     = load_use || md_hazard;

        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        if (branch_taken) begin
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
        end else if (stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
        stall_count_inc = stall && !branch_taken;
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_counter (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (stall_count_inc),
        .count(stall_cycles)
    );

endmodule
